sound_arbiter: RTL

Shares the single square-wave tone generator among several sound requesters: win/lose themes, level jingle, jump and collision effects. Each requester presents a request, a 4-bit note code and a note-enable. The arbiter grants exactly one owner using fixed priority, enforces a minimum hold time, and inserts a silence gap between owners. It forces release from a requester that holds too long. It sits between the per-sound sequencers and the tone/frequency divider.

---
 rtl/sound_pkg.sv | 35 +++
 rtl/sound_prio_enc.sv | 19 +
 rtl/sound_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound arbiter: note codes, FSM states and
// a helper that sizes the tick counters.
package sound_pkg;

  localparam int unsigned TONE_W = 4;

  typedef logic [TONE_W-1:0] tone_t;

  localparam tone_t NOTE_A  = TONE_W'(0);
  localparam tone_t NOTE_B  = TONE_W'(1);
  localparam tone_t NOTE_C  = TONE_W'(2);
  localparam tone_t NOTE_D  = TONE_W'(3);
  localparam tone_t NOTE_E  = TONE_W'(4);
  localparam tone_t NOTE_F  = TONE_W'(5);
  localparam tone_t NOTE_G  = TONE_W'(6);
  localparam tone_t NOTE_A2 = TONE_W'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Bits needed to hold the largest of the three tick limits without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Masked fixed-priority encoder: lowest set bit of (vec & ~mask) as a one-hot
// vector, plus a flag saying whether any bit survived the mask.
module sound_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] vec,
  input  logic [N-1:0] mask,
  output logic [N-1:0] onehot_c,
  output logic         valid_c
);

  logic [N-1:0] masked;

  assign masked   = vec & ~mask;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_c = masked & (~masked + N'(1));
  assign valid_c  = |masked;

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority owner arbitration for the shared tone generator, with
// watchdog release, silence gap and optional preemption (SOUND_ARB_PREEMPT_EN).
module sound_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TONE_W    = 4,
  parameter int unsigned MIN_HOLD  = 2,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned MAX_TICKS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TONE_W-1:0] req_tone,
  input  logic [NUM_REQ-1:0]        req_en,
  output logic [NUM_REQ-1:0]        grant,
  output logic [TONE_W-1:0]         tone,
  output logic                      enable_out,
  output logic                      busy
);

  import sound_pkg::*;

  localparam int unsigned CNT_W = cnt_width(MAX_TICKS, MIN_HOLD, GAP_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] WD_LIM   = CNT_W'(MAX_TICKS);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_TICKS);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [TONE_W-1:0]  tone_nxt;
  logic               en_nxt;
  logic               busy_nxt;
  logic [NUM_REQ-1:0] lock, lock_nxt, lock_set;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [CNT_W-1:0]   wd_cnt, wd_nxt;
  logic [CNT_W-1:0]   gap_cnt, gap_nxt;
  logic               release_own;

  logic [NUM_REQ-1:0] first_oh;
  logic               first_valid;
  logic [NUM_REQ-1:0] pick;
  logic [TONE_W-1:0]  pick_tone;
  logic               pick_en;
  logic               owner_req;

  // Lowest eligible requester; serves idle arbitration and the preemption test.
  sound_prio_enc #(
    .N (NUM_REQ)
  ) u_prio (
    .vec      (req),
    .mask     (lock),
    .onehot_c (first_oh),
    .valid_c  (first_valid)
  );

  // Note code / enable of the requester about to own (IDLE) or owning now.
  always_comb begin
    pick      = (state == IDLE) ? first_oh : grant;
    pick_tone = '0;
    pick_en   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_tone = pick_tone | req_tone[i*TONE_W +: TONE_W];
        pick_en   = pick_en | req_en[i];
      end
    end
  end

  assign owner_req = |(req & grant);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    tone_nxt    = '0;
    en_nxt      = 1'b0;
    hold_nxt    = hold_cnt;
    wd_nxt      = wd_cnt;
    gap_nxt     = gap_cnt;
    lock_set    = '0;
    release_own = 1'b0;

    case (state)
      IDLE: begin
        hold_nxt = '0;
        wd_nxt   = '0;
        gap_nxt  = '0;
        if (first_valid) begin
          state_nxt = OWN;
          grant_nxt = first_oh;
          tone_nxt  = pick_tone;
          en_nxt    = pick_en;
        end
      end

      OWN: begin
        // Owner drop outranks watchdog and preemption; only a live owner is locked.
        if (!owner_req) begin
          release_own = 1'b1;
        end else if (wd_cnt == WD_LIM) begin
          release_own = 1'b1;
          lock_set    = grant;
`ifdef SOUND_ARB_PREEMPT_EN
        end else if (first_valid && (first_oh < grant) && (hold_cnt == HOLD_LIM)) begin
          release_own = 1'b1;
`endif
        end else begin
          tone_nxt = pick_tone;
          en_nxt   = pick_en;
          if (tick) begin
            if (hold_cnt != HOLD_LIM) hold_nxt = hold_cnt + CNT_W'(1);
            if (wd_cnt != WD_LIM)     wd_nxt   = wd_cnt + CNT_W'(1);
          end
        end

        if (release_own) begin
          grant_nxt = '0;
          hold_nxt  = '0;
          wd_nxt    = '0;
          gap_nxt   = '0;
          state_nxt = (GAP_TICKS > 0) ? GAP : IDLE;
        end
      end

      GAP: begin
        grant_nxt = '0;
        if (tick) begin
          if ((gap_cnt + CNT_W'(1)) >= GAP_LIM) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
          end else begin
            gap_nxt = gap_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    lock_nxt = (lock | lock_set) & req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      tone       <= '0;
      enable_out <= 1'b0;
      busy       <= 1'b0;
      lock       <= '0;
      hold_cnt   <= '0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      tone       <= tone_nxt;
      enable_out <= en_nxt;
      busy       <= busy_nxt;
      lock       <= lock_nxt;
      hold_cnt   <= hold_nxt;
      wd_cnt     <= wd_nxt;
      gap_cnt    <= gap_nxt;
    end
  end

endmodule
